fir_coef_sram_ctrl: RTL and testbench

- Master-side controller for the FIR coefficient SRAM. The SRAM is single-port, 11 x 16, with active-low chip select and write enable and a one-cycle registered read.
- Accepts coefficient writes over a valid/ready interface and turns them into SRAM write cycles.
- On a start request, reads all taps out sequentially and streams them to the FIR MAC datapath with index and valid.

---
 rtl/fir_coef_sram_ctrl_if.sv | 27 ++
 rtl/fir_coef_sram_ctrl.sv | 145 ++++++++++++++
 tb/tb_fir_coef_sram_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_sram_ctrl_if.sv
// Coefficient write channel and single-port SRAM bus of the FIR coefficient store.
// master = controller side, slave = coefficient source / SRAM side.
interface fir_coef_sram_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              iCoefValid;
    logic [ADDR_W-1:0] iCoefAddr;
    logic [DATA_W-1:0] iCoefData;
    logic              oCoefReady;
    logic              oAddrErr;
    logic              oCsnRam;
    logic              oWrnRam;
    logic [ADDR_W-1:0] oAddrRam;
    logic [DATA_W-1:0] oWtDtRam;
    logic [DATA_W-1:0] iRdDtRam;

    modport master (
        input  iCoefValid, iCoefAddr, iCoefData, iRdDtRam,
        output oCoefReady, oAddrErr, oCsnRam, oWrnRam, oAddrRam, oWtDtRam
    );

    modport slave (
        output iCoefValid, iCoefAddr, iCoefData, iRdDtRam,
        input  oCoefReady, oAddrErr, oCsnRam, oWrnRam, oAddrRam, oWtDtRam
    );
endinterface

// File: rtl/fir_coef_sram_ctrl.sv
// FIR coefficient SRAM controller: handshaked writes, full-burst tap readout.
// Define FIR_TAP_REVERSE_EN to stream taps highest index first.
module fir_coef_sram_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_TAPS = 11
) (
    input  logic                iClk12M,
    input  logic                iRst,
    fir_coef_sram_ctrl_if.master bus,
    input  logic                iRdStart,
    output logic                oBusy,
    output logic                oTapValid,
    output logic [ADDR_W-1:0]   oTapIdx,
    output logic [DATA_W-1:0]   oTapData,
    output logic                oRdDone
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
`ifdef FIR_TAP_REVERSE_EN
    localparam logic [ADDR_W-1:0] FIRST_IDX = LAST_ADDR;
    localparam logic [ADDR_W-1:0] FINAL_IDX = '0;
`else
    localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
    localparam logic [ADDR_W-1:0] FINAL_IDX = LAST_ADDR;
`endif

    state_t            state, stateNxt;
    logic              pending, pendingNxt;
    logic [ADDR_W-1:0] rdCnt, rdCntNxt;
    logic              drainCnt, drainCntNxt;

    logic              csnNxt, wrnNxt, errNxt;
    logic [ADDR_W-1:0] addrNxt;
    logic [DATA_W-1:0] wdatNxt;

    logic              s1Valid, s1Last;
    logic [ADDR_W-1:0] s1Idx;

    logic              wrAccept, wrGood;

    assign bus.oCoefReady = (state == IDLE) && !pending;
    assign oBusy          = (state != IDLE);
    assign wrAccept       = bus.iCoefValid && bus.oCoefReady;
    assign wrGood         = wrAccept && ({1'b0, bus.iCoefAddr} < (ADDR_W + 1)'(NUM_TAPS));

    always_comb begin
        stateNxt    = state;
        pendingNxt  = pending;
        rdCntNxt    = rdCnt;
        drainCntNxt = drainCnt;
        if (iRdStart && (state == IDLE || state == WRITE))
            pendingNxt = 1'b1;
        case (state)
            IDLE: begin
                if (pending) begin
                    stateNxt   = READ;
                    pendingNxt = 1'b0;
                    rdCntNxt   = FIRST_IDX;
                end else if (wrGood) begin
                    stateNxt = WRITE;
                end
            end
            WRITE: stateNxt = IDLE;
            READ: begin
                if (rdCnt == FINAL_IDX) begin
                    stateNxt    = DRAIN;
                    drainCntNxt = 1'b0;
                end else begin
`ifdef FIR_TAP_REVERSE_EN
                    rdCntNxt = rdCnt - ONE;
`else
                    rdCntNxt = rdCnt + ONE;
`endif
                end
            end
            DRAIN: begin
                if (drainCnt) stateNxt = IDLE;
                else          drainCntNxt = 1'b1;
            end
            default: stateNxt = IDLE;
        endcase
    end

    // SRAM pins are registered, so they are decoded from the state being entered.
    always_comb begin
        csnNxt  = 1'b1;
        wrnNxt  = 1'b1;
        addrNxt = bus.oAddrRam;
        wdatNxt = bus.oWtDtRam;
        errNxt  = wrAccept && !wrGood;
        if (stateNxt == WRITE) begin
            csnNxt  = 1'b0;
            wrnNxt  = 1'b0;
            addrNxt = bus.iCoefAddr;
            wdatNxt = bus.iCoefData;
        end else if (stateNxt == READ) begin
            csnNxt  = 1'b0;
            addrNxt = rdCntNxt;
        end
    end

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state        <= IDLE;
            pending      <= 1'b0;
            rdCnt        <= '0;
            drainCnt     <= 1'b0;
            bus.oCsnRam  <= 1'b1;
            bus.oWrnRam  <= 1'b1;
            bus.oAddrRam <= '0;
            bus.oWtDtRam <= '0;
            bus.oAddrErr <= 1'b0;
            s1Valid      <= 1'b0;
            s1Last       <= 1'b0;
            s1Idx        <= '0;
            oTapValid    <= 1'b0;
            oTapIdx      <= '0;
            oTapData     <= '0;
            oRdDone      <= 1'b0;
        end else begin
            state        <= stateNxt;
            pending      <= pendingNxt;
            rdCnt        <= rdCntNxt;
            drainCnt     <= drainCntNxt;
            bus.oCsnRam  <= csnNxt;
            bus.oWrnRam  <= wrnNxt;
            bus.oAddrRam <= addrNxt;
            bus.oWtDtRam <= wdatNxt;
            bus.oAddrErr <= errNxt;
            // Stage 1 tracks the SRAM read cycle; stage 2 registers the returned word.
            s1Valid      <= (state == READ);
            s1Last       <= (state == READ) && (rdCnt == FINAL_IDX);
            s1Idx        <= rdCnt;
            oTapValid    <= s1Valid;
            oRdDone      <= s1Valid && s1Last;
            if (s1Valid) begin
                oTapIdx  <= s1Idx;
                oTapData <= bus.iRdDtRam;
            end
        end
    end
endmodule

// File: tb/tb_fir_coef_sram_ctrl.sv
// Directed bench for fir_coef_sram_ctrl with a behavioural 16 x 16 SRAM.
// Honours FIR_TAP_REVERSE_EN for the expected tap order.
module tb_fir_coef_sram_ctrl;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_TAPS = 11;
`ifdef FIR_TAP_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic              iClk12M;
    logic              iRst;
    logic              iRdStart;
    logic              oBusy;
    logic              oTapValid;
    logic [ADDR_W-1:0] oTapIdx;
    logic [DATA_W-1:0] oTapData;
    logic              oRdDone;

    fir_coef_sram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fir_coef_sram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TAPS(NUM_TAPS)) dut (
        .iClk12M  (iClk12M),
        .iRst     (iRst),
        .bus      (bus.master),
        .iRdStart (iRdStart),
        .oBusy    (oBusy),
        .oTapValid(oTapValid),
        .oTapIdx  (oTapIdx),
        .oTapData (oTapData),
        .oRdDone  (oRdDone)
    );

    initial iClk12M = 1'b0;
    always #42 iClk12M = ~iClk12M;

    logic [DATA_W-1:0] sram [0:15];
    always @(posedge iClk12M) begin
        if (!bus.oCsnRam) begin
            if (!bus.oWrnRam) sram[bus.oAddrRam] <= bus.oWtDtRam;
            else              bus.iRdDtRam <= sram[bus.oAddrRam];
        end
    end

    int nChecks = 0;
    int nFails  = 0;

    logic [DATA_W-1:0] expMem [0:NUM_TAPS-1];
    logic [ADDR_W-1:0] capIdx [0:31];
    logic [DATA_W-1:0] capData [0:31];
    int tapCount, doneCount, gaps, badAddr, deadSeen, lastValidN;
    int firstAddrN, firstWriteN, firstTapN, doneN;
    logic [ADDR_W-1:0] doneIdx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int expIdx(input int i);
        return REV ? (NUM_TAPS - 1 - i) : i;
    endfunction

    task automatic writeGood(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        chk("wrReady", 32'(bus.oCoefReady), 32'd1);
        bus.iCoefValid = 1'b1;
        bus.iCoefAddr  = a;
        bus.iCoefData  = d;
        @(negedge iClk12M);
        bus.iCoefValid = 1'b0;
        chk($sformatf("wrCsn[%0d]", a), 32'(bus.oCsnRam), 32'd0);
        chk($sformatf("wrWrn[%0d]", a), 32'(bus.oWrnRam), 32'd0);
        chk($sformatf("wrAddr[%0d]", a), 32'(bus.oAddrRam), 32'(a));
        chk($sformatf("wrData[%0d]", a), 32'(bus.oWtDtRam), 32'(d));
        expMem[a] = d;
        @(negedge iClk12M);
        chk($sformatf("wrOneCycle[%0d]", a), 32'(bus.oCsnRam), 32'd1);
    endtask

    // Caller sets the start stimulus at the current negedge; n counts edges since then.
    task automatic collectBurst(input int nCycles, input int midStartAt, input int resetAtTap);
        tapCount = 0; doneCount = 0; gaps = 0; badAddr = 0; deadSeen = 0;
        lastValidN = -1; firstAddrN = -1; firstWriteN = -1; firstTapN = -1; doneN = -1;
        doneIdx = '0;
        for (int n = 1; n <= nCycles; n++) begin
            @(negedge iClk12M);
            if (n == 1) begin
                iRdStart       = 1'b0;
                bus.iCoefValid = 1'b0;
            end
            if (n == midStartAt)     iRdStart = 1'b1;
            if (n == midStartAt + 1) iRdStart = 1'b0;
            if (!bus.oCsnRam && !bus.oWrnRam && firstWriteN < 0) firstWriteN = n;
            if (!bus.oCsnRam && bus.oWrnRam && firstAddrN < 0)   firstAddrN = n;
            if (!bus.oCsnRam && bus.oAddrRam >= ADDR_W'(NUM_TAPS)) badAddr++;
            if (oTapValid) begin
                if (tapCount < 32) begin
                    capIdx[tapCount]  = oTapIdx;
                    capData[tapCount] = oTapData;
                end
                tapCount++;
                if (firstTapN < 0) firstTapN = n;
                if (lastValidN >= 0 && lastValidN != n - 1) gaps++;
                lastValidN = n;
                if (oTapData == 16'hDEAD) deadSeen++;
            end
            if (oRdDone) begin
                doneCount++;
                doneN   = n;
                doneIdx = oTapIdx;
            end
            if (resetAtTap > 0 && tapCount == resetAtTap) begin
                iRst = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkBurst(input string tag);
        chk({tag, ".tapCount"}, 32'(tapCount), 32'(NUM_TAPS));
        chk({tag, ".doneCount"}, 32'(doneCount), 32'd1);
        chk({tag, ".gaps"}, 32'(gaps), 32'd0);
        chk({tag, ".badAddr"}, 32'(badAddr), 32'd0);
        chk({tag, ".deadSeen"}, 32'(deadSeen), 32'd0);
        chk({tag, ".doneIdx"}, 32'(doneIdx), 32'(expIdx(NUM_TAPS - 1)));
        chk({tag, ".doneWithLast"}, 32'(doneN), 32'(lastValidN));
        for (int i = 0; i < NUM_TAPS; i++) begin
            chk($sformatf("%s.idx[%0d]", tag, i), 32'(capIdx[i]), 32'(expIdx(i)));
            chk($sformatf("%s.data[%0d]", tag, i), 32'(capData[i]), 32'(expMem[expIdx(i)]));
        end
    endtask

    initial begin
        iRst           = 1'b1;
        iRdStart       = 1'b0;
        bus.iCoefValid = 1'b0;
        bus.iCoefAddr  = '0;
        bus.iCoefData  = '0;

        // Reset
        @(negedge iClk12M);
        @(negedge iClk12M);
        chk("rstCsn", 32'(bus.oCsnRam), 32'd1);
        chk("rstWrn", 32'(bus.oWrnRam), 32'd1);
        chk("rstAddr", 32'(bus.oAddrRam), 32'd0);
        chk("rstWdat", 32'(bus.oWtDtRam), 32'd0);
        chk("rstTapValid", 32'(oTapValid), 32'd0);
        chk("rstTapIdx", 32'(oTapIdx), 32'd0);
        chk("rstTapData", 32'(oTapData), 32'd0);
        chk("rstRdDone", 32'(oRdDone), 32'd0);
        chk("rstAddrErr", 32'(bus.oAddrErr), 32'd0);
        chk("rstBusy", 32'(oBusy), 32'd0);
        chk("rstReady", 32'(bus.oCoefReady), 32'd1);
        iRst = 1'b0;
        @(negedge iClk12M);

        // Write then read
        for (int k = 0; k < NUM_TAPS; k++)
            writeGood(ADDR_W'(k), 16'h0100 + 16'(k));
        iRdStart = 1'b1;
        collectBurst(30, 0, 0);
        checkBurst("burstA");
        chk("burstA.firstAddrN", 32'(firstAddrN), 32'd2);
        chk("burstA.firstTapN", 32'(firstTapN), 32'd4);
        chk("burstA.doneN", 32'(doneN), 32'd14);
        chk("holdTapValid", 32'(oTapValid), 32'd0);
        chk("holdTapIdx", 32'(oTapIdx), 32'(expIdx(NUM_TAPS - 1)));
        chk("holdTapData", 32'(oTapData), 32'(expMem[expIdx(NUM_TAPS - 1)]));
        chk("idleBusy", 32'(oBusy), 32'd0);

        // Bad address
        chk("badReady", 32'(bus.oCoefReady), 32'd1);
        bus.iCoefValid = 1'b1;
        bus.iCoefAddr  = 4'hB;
        bus.iCoefData  = 16'hDEAD;
        @(negedge iClk12M);
        bus.iCoefValid = 1'b0;
        chk("badErrPulse", 32'(bus.oAddrErr), 32'd1);
        chk("badCsn", 32'(bus.oCsnRam), 32'd1);
        chk("badBusy", 32'(oBusy), 32'd0);
        @(negedge iClk12M);
        chk("badErrOneCycle", 32'(bus.oAddrErr), 32'd0);
        chk("badCsn2", 32'(bus.oCsnRam), 32'd1);
        iRdStart = 1'b1;
        collectBurst(30, 0, 0);
        checkBurst("burstB");

        // Collision: write and start together
        bus.iCoefValid = 1'b1;
        bus.iCoefAddr  = 4'd3;
        bus.iCoefData  = 16'h5555;
        iRdStart       = 1'b1;
        expMem[3]      = 16'h5555;
        collectBurst(30, 0, 0);
        chk("colWriteN", 32'(firstWriteN), 32'd1);
        chk("colFirstAddrN", 32'(firstAddrN), 32'd3);
        chk("colSramWord", 32'(sram[3]), 32'h5555);
        checkBurst("burstC");

        // Start pulse during READ is ignored
        iRdStart = 1'b1;
        collectBurst(45, 6, 0);
        checkBurst("burstD");
        chk("burstD.idleAfter", 32'(oBusy), 32'd0);

        // Reset at tap 5 of a new burst
        iRdStart = 1'b1;
        collectBurst(30, 0, 6);
        chk("midRstReached", 32'(tapCount), 32'd6);
        @(negedge iClk12M);
        chk("midRstBusy", 32'(oBusy), 32'd0);
        chk("midRstTapValid", 32'(oTapValid), 32'd0);
        chk("midRstCsn", 32'(bus.oCsnRam), 32'd1);
        chk("midRstReady", 32'(bus.oCoefReady), 32'd1);
        iRst = 1'b0;
        collectBurst(15, 0, 0);
        chk("midRstNoTaps", 32'(tapCount), 32'd0);
        chk("midRstNoRead", 32'(firstAddrN), 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
